// File: rtl/piano_mem_pkg.sv
// Shared definitions for the piano memory arbiters (SRAM now, flash later).
package piano_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 13;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned ST_W        = 2;
  localparam int unsigned WAIT_W      = 8;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY    = 2'd1;
  localparam logic [ST_W-1:0] ST_RELEASE = 2'd2;

  // Round-robin winner index; with both requesting, the one not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1 && !req0;
  endfunction

endpackage

// File: rtl/arb_timeout.sv
// Wait counter for the BUSY phase: clears while disabled, counts while enabled.
module arb_timeout import piano_mem_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc_c
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: zero outside BUSY so every entry starts from 0.
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = cnt_q + WAIT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Terminal count: the edge at the end of this cycle brings the count to TIMEOUT.
  assign tc_c = en && (cnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of SRAMControl.
module sram_arbiter import piano_mem_pkg::*; #(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_writeEnable,
  output logic              mem_requestCE,
  input  logic [DATA_W-1:0] mem_dataOut,
  input  logic              mem_CE
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err_q, err_d;
  logic              rce_q, rce_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win_c;
  logic              tc_c;

  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (state_q == ST_BUSY),
    .tc_c  (tc_c)
  );

  // Next state and registered outputs; the SRAM side only ever sees latched values.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    rce_d   = rce_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win_c   = rr_pick(req0, req1, last_q);
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_BUSY;
          owner_d = win_c;
          gnt0_d  = !win_c;
          gnt1_d  = win_c;
          rce_d   = 1'b1;
          we_d    = win_c ? we1 : we0;
          addr_d  = win_c ? addr1 : addr0;
          wdata_d = win_c ? wdata1 : wdata0;
        end
      end
      ST_BUSY: begin
        if (mem_CE || tc_c) begin
          state_d = ST_RELEASE;
          ack0_d  = !owner_q;
          ack1_d  = owner_q;
          err_d   = !mem_CE;
          // A timed-out transaction still counts as served so the other side cannot starve.
          last_d  = owner_q;
          if (mem_CE && !we_q) rdata_d = mem_dataOut;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          rce_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rce_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      rce_q   <= rce_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt0            = gnt0_q;
  assign gnt1            = gnt1_q;
  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign err             = err_q;
  assign rdata           = rdata_q;
  assign mem_address     = addr_q;
  assign mem_dataIn      = wdata_q;
  assign mem_writeEnable = we_q;
  assign mem_requestCE   = rce_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level model predicts service order and results.
module tb_sram_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int TO = 15;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, mem_address;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_dataIn, mem_dataOut;
  logic          gnt0, gnt1, ack0, ack1, err, mem_writeEnable, mem_requestCE, mem_CE;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_writeEnable(mem_writeEnable), .mem_requestCE(mem_requestCE),
    .mem_dataOut(mem_dataOut), .mem_CE(mem_CE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;       // BUSY cycle index (0-based) in which the memory answers
    logic [DW-1:0] rd;
    logic          drop;      // requester lowers req while being served
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } txn_t;

  txn_t q0[$], q1[$];   // per-requester pending work (drives req/we/addr/wdata)
  txn_t s0[$], s1[$];   // staging for the next round
  txn_t exp_q[$];       // predicted service order
  logic          last_m  = 1'b1;
  logic [DW-1:0] rdata_m = '0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic txn_t mk_txn(input logic owner, input logic we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rd);
    txn_t t;
    t.owner = owner; t.we = we; t.addr = addr; t.wdata = wdata;
    t.lat = lat; t.rd = rd; t.drop = 1'b0; t.exp_rdata = '0; t.exp_err = 1'b0;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input logic owner);
    txn_t t;
    int lat;
    lat = ($urandom % 8 == 0) ? TO + int'($urandom % 5) : int'($urandom % 6);
    t = mk_txn(owner, 1'($urandom), AW'($urandom), DW'($urandom), lat, DW'($urandom));
    t.drop = ($urandom % 4 == 0);
    return t;
  endfunction

  // Reference: serve pending work one at a time; with both waiting, the one not served last goes.
  task automatic plan_round();
    int i0, i1;
    logic w;
    txn_t t;
    i0 = 0; i1 = 0;
    while (i0 < s0.size() || i1 < s1.size()) begin
      if (i0 < s0.size() && i1 < s1.size()) w = ~last_m;
      else                                  w = (i1 < s1.size());
      if (w) begin t = s1[i1]; i1++; end
      else   begin t = s0[i0]; i0++; end
      t.exp_err = (t.lat >= TO);
      if (!t.we && !t.exp_err) rdata_m = t.rd;
      t.exp_rdata = rdata_m;
      last_m = w;
      exp_q.push_back(t);
    end
    foreach (s0[k]) q0.push_back(s0[k]);
    foreach (s1[k]) q1.push_back(s1[k]);
    s0.delete();
    s1.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL round_timeout: got pending %0d/%0d want 0/0", q0.size(), q1.size());
      q0.delete(); q1.delete(); exp_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  // Requester agents: hold req with the head item until its ack.
  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    forever begin
      @(negedge CLK);
      if (ack0 && q0.size() != 0) q0.delete(0);
      if (ack1 && q1.size() != 0) q1.delete(0);
      if (q0.size() == 0) req0 = 1'b0;
      else if (gnt0 && q0[0].drop) begin
        req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
      end else begin
        req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
      end
      if (q1.size() == 0) req1 = 1'b0;
      else if (gnt1 && q1[0].drop) begin
        req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
      end else begin
        req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
      end
    end
  end

  // SRAM model: answers in the planned BUSY cycle; noise elsewhere.
  initial begin
    int cyc;
    int lat;
    logic prev;
    cyc = 0; prev = 1'b0; mem_CE = 1'b0; mem_dataOut = '0;
    forever begin
      @(negedge CLK);
      lat = (exp_q.size() != 0) ? exp_q[0].lat : 0;
      if (mem_requestCE) begin
        cyc = prev ? cyc + 1 : 0;
        mem_CE = (cyc == lat);
        mem_dataOut = (cyc == lat && exp_q.size() != 0) ? exp_q[0].rd : DW'($urandom);
      end else begin
        mem_CE = 1'($urandom);
        mem_dataOut = DW'($urandom);
      end
      prev = mem_requestCE;
    end
  end

  // Monitor: compare grants and acks against the predicted order.
  initial begin
    logic pg, pa, g, a;
    int cyc, gcyc, want_lat;
    txn_t t;
    pg = 0; pa = 0; cyc = 0; gcyc = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (!RST_N) begin pg = 0; pa = 0; continue; end
      g = gnt0 | gnt1;
      a = ack0 | ack1;
      chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'(0));
      if (g && !pg) begin
        if (exp_q.size() == 0) chk("grant_unexpected", 64'(g), 64'(0));
        else begin
          t = exp_q[0];
          chk("grant_owner", 64'({gnt1, gnt0}), t.owner ? 64'(2) : 64'(1));
          chk("busy_requestCE", 64'(mem_requestCE), 64'(1));
          chk("busy_address", 64'(mem_address), 64'(t.addr));
          chk("busy_writeEnable", 64'(mem_writeEnable), 64'(t.we));
          if (t.we) chk("busy_dataIn", 64'(mem_dataIn), 64'(t.wdata));
        end
        gcyc = cyc;
      end
      if (a) begin
        if (exp_q.size() == 0) chk("ack_unexpected", 64'(a), 64'(0));
        else begin
          t = exp_q.pop_front();
          want_lat = (t.lat >= TO) ? TO : t.lat + 1;
          chk("ack_owner", 64'({ack1, ack0}), t.owner ? 64'(2) : 64'(1));
          chk("ack_err", 64'(err), 64'(t.exp_err));
          chk("ack_rdata", 64'(rdata), 64'(t.exp_rdata));
          chk("ack_latency", 64'(cyc - gcyc), 64'(want_lat));
          chk("release_quiet", 64'({gnt0, gnt1, mem_requestCE, mem_writeEnable}), 64'(0));
        end
      end else chk("err_without_ack", 64'(err), 64'(0));
      if (pa) chk("idle_after_release", 64'({ack0, ack1, err, gnt0, gnt1, mem_requestCE}), 64'(0));
      pg = g;
      pa = a;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus.
  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_gnt", 64'({gnt0, gnt1}), 64'(0));
    chk("rst_ack_err", 64'({ack0, ack1, err}), 64'(0));
    chk("rst_mem_ctl", 64'({mem_requestCE, mem_writeEnable}), 64'(0));
    chk("rst_mem_address", 64'(mem_address), 64'(0));
    chk("rst_mem_dataIn", 64'(mem_dataIn), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    RST_N = 1'b1;
    @(negedge CLK);

    // Contention from reset: two items each, expect 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      s0.push_back(mk_txn(1'b0, 1'($urandom), AW'($urandom), DW'($urandom), int'($urandom % 4), DW'($urandom)));
      s1.push_back(mk_txn(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), int'($urandom % 4), DW'($urandom)));
    end
    plan_round(); wait_idle();

    // Single read, memory answers two cycles into BUSY.
    s0.push_back(mk_txn(1'b0, 1'b0, AW'(50), DW'(0), 2, DW'(21)));
    plan_round(); wait_idle();
    // Write accepted immediately; rdata must keep 21.
    s1.push_back(mk_txn(1'b1, 1'b1, AW'(35), DW'(12), 0, DW'(99)));
    plan_round(); wait_idle();
    // Memory never answers: timeout.
    s0.push_back(mk_txn(1'b0, 1'b0, AW'(7), DW'(0), 40, DW'(5)));
    plan_round(); wait_idle();

    // Random rounds.
    for (int r = 0; r < 30; r++) begin
      int n0, n1;
      n0 = int'($urandom % 3);
      n1 = int'($urandom % 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++) s0.push_back(rnd_txn(1'b0));
      for (int k = 0; k < n1; k++) s1.push_back(rnd_txn(1'b1));
      plan_round(); wait_idle();
    end

    // Reset while requester 1 is being served.
    s1.push_back(mk_txn(1'b1, 1'b0, AW'(9), DW'(0), 40, DW'(3)));
    plan_round();
    n = 0;
    while (!gnt1 && n < 50) begin @(negedge CLK); n++; end
    chk("rst_busy_grant_seen", 64'(gnt1), 64'(1));
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_busy_requestCE", 64'(mem_requestCE), 64'(0));
    chk("rst_busy_gnt", 64'({gnt0, gnt1}), 64'(0));
    q0.delete(); q1.delete(); exp_q.delete();
    last_m = 1'b1; rdata_m = '0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_busy_no_ack", 64'({ack0, ack1, err}), 64'(0));
    end
    RST_N = 1'b1;
    @(negedge CLK);
    s0.push_back(mk_txn(1'b0, 1'b1, AW'(1), DW'(2), 1, DW'(0)));
    s1.push_back(mk_txn(1'b1, 1'b1, AW'(3), DW'(4), 1, DW'(0)));
    plan_round(); wait_idle();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
